// File: rtl/l0_skew_buf_pkg.sv
// Shared types and width helpers for the L0 skew buffer and its row FIFOs.
package l0_pkg;

   typedef enum logic {L0_BCAST = 1'b0, L0_SKEW = 1'b1} l0_mode_t;

   localparam int L0_DEPTH_DEF = 64;
   localparam int L0_PTR_W_DEF = $clog2(L0_DEPTH_DEF);
   localparam int L0_CNT_W_DEF = L0_PTR_W_DEF + 1;

   function automatic int l0_ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   // One extra bit so a full FIFO (count == DEPTH) is distinguishable from empty.
   function automatic int l0_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/l0_skew_buf_if.sv
// Bus bundle for l0_skew_buf: write/read requests in, per-row data and status out.
// Handshake: a write is taken on any clock edge where wr && o_ready; rd has no
// back-pressure and a read of an empty row is flagged through o_underflow.
interface l0_skew_buf_if
   import l0_pkg::*;
#(
   parameter int ROW   = 8,
   parameter int BW    = 4,
   parameter int DEPTH = 64
);
   localparam int CNT_W = l0_cnt_w(DEPTH);

   logic                 wr;
   logic [ROW*BW-1:0]    in;
   logic                 rd;
   logic                 mode;
   logic [ROW*BW-1:0]    out;
   logic [ROW-1:0]       o_valid;
   logic                 o_ready;
   logic                 o_full;
   logic                 o_empty;
   logic                 o_overflow;
   logic                 o_underflow;
   logic [CNT_W-1:0]     o_count;
   logic [ROW*CNT_W-1:0] dbg_count;
   l0_mode_t             dbg_mode;

   modport master (
      output wr, in, rd, mode,
      input  out, o_valid, o_ready, o_full, o_empty, o_overflow, o_underflow,
             o_count, dbg_count, dbg_mode
   );

   modport slave (
      input  wr, in, rd, mode,
      output out, o_valid, o_ready, o_full, o_empty, o_overflow, o_underflow,
             o_count, dbg_count, dbg_mode
   );

endinterface

// File: rtl/l0_skew_buf_row_fifo.sv
// Single-clock row FIFO with a registered read port; reads of an empty FIFO are ignored.
module l0_row_fifo
   import l0_pkg::*;
#(
   parameter int BW    = 4,
   parameter int DEPTH = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr,
   input  logic                       rd,
   input  logic [BW-1:0]              in,
   output logic [BW-1:0]              out,
   output logic                       o_valid,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [l0_cnt_w(DEPTH)-1:0] o_count
);
   localparam int PTR_W = l0_ptr_w(DEPTH);
   localparam int CNT_W = l0_cnt_w(DEPTH);

   logic [BW-1:0]    mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_wr;
   logic             do_rd;

   assign o_full  = (count == CNT_W'(DEPTH));
   assign o_empty = (count == '0);
   assign o_count = count;

   // No bypass: a read only sees data already stored before this edge.
   assign do_wr = wr && !o_full;
   assign do_rd = rd && !o_empty;

   always_ff @(posedge clk) begin
      if (do_wr && !reset) begin
         mem[wr_ptr] <= in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         out     <= '0;
         o_valid <= 1'b0;
      end else begin
         o_valid <= do_rd;
         if (do_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
            out    <= mem[rd_ptr];
         end
         count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
      end
   end

endmodule

// File: rtl/l0_skew_buf.sv
// Row-bank input buffer for the systolic array west edge: one FIFO per row,
// read either in broadcast or as a diagonal (skewed) wavefront.
module l0_skew_buf
   import l0_pkg::*;
#(
   parameter int ROW   = 8,
   parameter int BW    = 4,
   parameter int DEPTH = 64
) (
   input logic           clk,
   input logic           reset,
   l0_skew_buf_if.slave  bus
);
   localparam int CNT_W = l0_cnt_w(DEPTH);

   logic [ROW-1:0] rd_en;
   logic [ROW-1:0] full_vec;
   logic [ROW-1:0] empty_vec;
   l0_mode_t       mode_q;
   logic           wr_acc;
   logic           overflow_q;
   logic           underflow_q;

   assign bus.o_ready     = ~|full_vec;
   assign bus.o_full      = &full_vec;
   assign bus.o_empty     = &empty_vec;
   assign bus.o_overflow  = overflow_q;
   assign bus.o_underflow = underflow_q;
   assign bus.o_count     = bus.dbg_count[CNT_W-1:0];
   assign bus.dbg_mode    = mode_q;

   // All rows share one write decision so their contents stay aligned.
   assign wr_acc = bus.wr && bus.o_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_en       <= '0;
         mode_q      <= L0_BCAST;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         // Mode only changes with the chain drained, so a wavefront never mixes modes.
         if (rd_en == '0 && !bus.rd) begin
            mode_q <= l0_mode_t'(bus.mode);
         end
         if (mode_q == L0_SKEW) begin
            rd_en <= {rd_en[ROW-2:0], bus.rd};
         end else begin
            rd_en <= {ROW{bus.rd}};
         end
         if (bus.wr && !bus.o_ready) begin
            overflow_q <= 1'b1;
         end
         if ((rd_en & empty_vec) != '0) begin
            underflow_q <= 1'b1;
         end
      end
   end

   for (genvar i = 0; i < ROW; i++) begin : g_row
      l0_row_fifo #(
         .BW    (BW),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk     (clk),
         .reset   (reset),
         .wr      (wr_acc),
         .rd      (rd_en[i]),
         .in      (bus.in[i*BW +: BW]),
         .out     (bus.out[i*BW +: BW]),
         .o_valid (bus.o_valid[i]),
         .o_full  (full_vec[i]),
         .o_empty (empty_vec[i]),
         .o_count (bus.dbg_count[i*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_l0_skew_buf.sv
// Directed and randomized bench for l0_skew_buf against a cycle-scheduled reference model.
module tb_l0_skew_buf;
   import l0_pkg::*;

   localparam int ROW   = 8;
   localparam int BW    = 4;
   localparam int DEPTH = 64;
   localparam int W     = ROW * BW;

   // clock / reset
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   l0_skew_buf_if #(.ROW(ROW), .BW(BW), .DEPTH(DEPTH)) bus ();

   l0_skew_buf #(.ROW(ROW), .BW(BW), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;

   // reference model: every accepted write vector, per-row read progress and
   // a table of scheduled row reads keyed by (absolute edge, row)
   logic [W-1:0]   exp_q[$];
   int             wr_cnt;
   int             rd_cnt[ROW];
   bit             sched[int];
   int             cyc = 0;
   bit             m_skew;
   logic [W-1:0]   exp_out;
   logic [ROW-1:0] exp_valid;
   bit             exp_ovf;
   bit             exp_udf;

   task automatic model_reset();
      exp_q.delete();
      wr_cnt = 0;
      for (int k = 0; k < ROW; k++) rd_cnt[k] = 0;
      sched.delete();
      m_skew    = 1'b0;
      exp_out   = '0;
      exp_valid = '0;
      exp_ovf   = 1'b0;
      exp_udf   = 1'b0;
   endtask

   task automatic model_edge(input bit w, input logic [W-1:0] d, input bit r, input bit m);
      bit           any_full;
      bit           pending;
      logic [W-1:0] vec;
      int           e;
      any_full = 1'b0;
      pending  = 1'b0;
      for (int k = 0; k < ROW; k++)
         if (wr_cnt - rd_cnt[k] == DEPTH) any_full = 1'b1;
      for (int k = 0; k < ROW; k++) begin
         exp_valid[k] = 1'b0;
         if (sched.exists(cyc * ROW + k)) begin
            pending = 1'b1;
            sched.delete(cyc * ROW + k);
            if (wr_cnt > rd_cnt[k]) begin
               vec = exp_q[rd_cnt[k]];
               exp_out[k*BW +: BW] = vec[k*BW +: BW];
               rd_cnt[k]++;
               exp_valid[k] = 1'b1;
            end else begin
               exp_udf = 1'b1;
            end
         end
      end
      if (r) begin
         for (int k = 0; k < ROW; k++) begin
            e = m_skew ? cyc + 1 + k : cyc + 1;
            sched[e * ROW + k] = 1'b1;
         end
      end
      if (!pending && !r) m_skew = m;
      if (w) begin
         if (!any_full) begin
            exp_q.push_back(d);
            wr_cnt++;
         end else begin
            exp_ovf = 1'b1;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic check_all();
      bit full_all, empty_all, none_full;
      full_all  = 1'b1;
      empty_all = 1'b1;
      none_full = 1'b1;
      for (int k = 0; k < ROW; k++) begin
         if (wr_cnt - rd_cnt[k] != DEPTH) full_all = 1'b0;
         else none_full = 1'b0;
         if (wr_cnt - rd_cnt[k] != 0) empty_all = 1'b0;
      end
      chk("out",       bus.out,                exp_out);
      chk("o_valid",   W'(bus.o_valid),        W'(exp_valid));
      chk("o_ready",   W'(bus.o_ready),        W'(none_full));
      chk("o_full",    W'(bus.o_full),         W'(full_all));
      chk("o_empty",   W'(bus.o_empty),        W'(empty_all));
      chk("overflow",  W'(bus.o_overflow),     W'(exp_ovf));
      chk("underflow", W'(bus.o_underflow),    W'(exp_udf));
      chk("o_count",   W'(bus.o_count),        W'(wr_cnt - rd_cnt[0]));
   endtask

   // driver tasks
   task automatic step(input bit w, input logic [W-1:0] d, input bit r, input bit m);
      bus.wr   = w;
      bus.in   = d;
      bus.rd   = r;
      bus.mode = m;
      @(posedge clk);
      model_edge(w, d, r, m);
      cyc++;
      #1 check_all();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      model_reset();
      cyc++;
      #1 check_all();
      reset = 1'b0;
   endtask

   task automatic idle(input int n, input bit m);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, m);
   endtask

   logic [W-1:0] pat;

   initial begin
      reset    = 1'b1;
      bus.wr   = 1'b0;
      bus.in   = '0;
      bus.rd   = 1'b0;
      bus.mode = 1'b0;
      for (int i = 0; i < ROW; i++) pat[i*BW +: BW] = BW'(i + 1);

      // reset state
      do_reset();
      do_reset();

      // skewed wavefront of the row-index pattern
      idle(1, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, pat, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b1);
      idle(12, 1'b1);

      // broadcast read of the same pattern, ending empty
      idle(1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, pat, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
      idle(4, 1'b0);

      // fill to DEPTH, one dropped write, then read everything back
      for (int i = 0; i < DEPTH + 1; i++) step(1'b1, W'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
      idle(3, 1'b0);

      // reads of an empty buffer, then reset clears sticky flags
      for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0);
      idle(3, 1'b0);
      do_reset();

      // mode toggled mid-wavefront only applies to the next burst
      idle(1, 1'b1);
      for (int i = 0; i < 12; i++) step(1'b1, W'($urandom), 1'b0, 1'b1);
      step(1'b0, '0, 1'b1, 1'b1);
      step(1'b0, '0, 1'b1, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      idle(12, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
      idle(4, 1'b0);

      // sustained write+read across pointer wrap, then reset mid-stream
      do_reset();
      idle(1, 1'b0);
      for (int i = 0; i < DEPTH / 2; i++) step(1'b1, W'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < DEPTH + 10; i++) step(1'b1, W'($urandom), 1'b1, 1'b0);
      do_reset();
      idle(3, 1'b0);

      // randomized traffic with occasional mode flips
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 2) == 0,
              $urandom_range(0, 15) == 0 ? ~bus.mode : bus.mode);
      end
      idle(ROW + 2, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
